// File: rtl/runner_ctrl_if.sv
// Signal bundle between the runner game-loop sequencer and the blocks it drives.
// The master modport is the sequencer side; the slave modport is the painter, keys and consumers.
interface runner_ctrl_if #(
    parameter int SCORE_W = 17,
    parameter int SPEED_W = 14
);
    logic               painter_finished;
    logic               jumping;
    logic               pause;
    logic               crashed;
    logic [SCORE_W-1:0] score;

    logic [1:0]         state;
    logic               update;
    logic [5:0]         timer;
    logic [SPEED_W-1:0] speed;
    logic               start;
    logic               restart;
    logic               has_obstacles;
    logic               rng_load;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;

    modport master (
        input  painter_finished, jumping, pause, crashed, score,
        output state, update, timer, speed, start, restart,
               has_obstacles, rng_load, high_score, new_high
    );

    modport slave (
        output painter_finished, jumping, pause, crashed, score,
        input  state, update, timer, speed, start, restart,
               has_obstacles, rng_load, high_score, new_high
    );
endinterface

// File: rtl/runner_ctrl.sv
// Game-loop sequencer for the runner game: frame edges become update ticks that drive the
// WAITING/RUNNING/PAUSED/CRASHED machine, the speed ramp, obstacle gating and high-score latch.
module runner_ctrl #(
    parameter int FPS           = 60,
    parameter int SPEED_SCALE   = 1024,
    parameter int SPEED         = 6 * 1024,
    parameter int MAX_SPEED     = 13 * 1024,
    parameter int ACCELERATION  = 1,
    parameter int CLEAR_TIME    = 180,
    parameter int RESTART_DELAY = 45,
    parameter int SCORE_W       = 17
) (
    input  logic          clk,
    input  logic          rst,
    runner_ctrl_if.master bus
);
    localparam int SPEED_W = $clog2(MAX_SPEED + 1);
    localparam int CLEAR_W = $clog2(CLEAR_TIME + 1);
    localparam int CRASH_W = $clog2(RESTART_DELAY + 1);

    localparam logic [1:0] ST_WAITING = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_CRASHED = 2'd3;

    localparam logic [SPEED_W-1:0] SPEED_START = SPEED_W'(SPEED);
    localparam logic [SPEED_W:0]   SPEED_CAP   = (SPEED_W + 1)'(MAX_SPEED);
    localparam logic [SPEED_W:0]   SPEED_STEP  = (SPEED_W + 1)'(ACCELERATION);
    localparam logic [CLEAR_W-1:0] CLEAR_MAX   = CLEAR_W'(CLEAR_TIME);
    localparam logic [CRASH_W-1:0] CRASH_MAX   = CRASH_W'(RESTART_DELAY);
    localparam logic [5:0]         TIMER_LAST  = 6'(FPS - 1);

    // The speed ramp and the 6-bit timer only make sense for these ranges.
    if (MAX_SPEED < SPEED || SPEED_SCALE < 1 || FPS < 1 || FPS > 64) begin : g_param_check
        $error("runner_ctrl: inconsistent speed or frame-rate parameters");
    end

    logic [1:0]         state_q,      state_d;
    logic               pf_last_q;
    logic               pause_last_q, pause_last_d;
    logic               update_q,     update_d;
    logic [5:0]         timer_q,      timer_d;
    logic [SPEED_W-1:0] speed_q,      speed_d;
    logic               start_q,      start_d;
    logic               restart_q,    restart_d;
    logic               has_obs_q,    has_obs_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               new_high_q,   new_high_d;
    logic [CLEAR_W-1:0] clear_cnt_q,  clear_cnt_d;
    logic [CRASH_W-1:0] crash_cnt_q,  crash_cnt_d;

    logic               frame_edge;
    logic               sample;
    logic               pause_press;
    logic [SPEED_W:0]   speed_sum;
    logic [SPEED_W-1:0] speed_inc;
    logic [5:0]         timer_inc;

    assign frame_edge  = bus.painter_finished & ~pf_last_q;
    // PAUSED has no update ticks, so the pause key is sampled on raw frame edges there instead.
    assign sample      = (state_q == ST_PAUSED) ? frame_edge : update_q;
    assign pause_press = bus.pause & ~pause_last_q;

    assign speed_sum = {1'b0, speed_q} + SPEED_STEP;
    assign speed_inc = (speed_sum > SPEED_CAP) ? SPEED_CAP[SPEED_W-1:0] : speed_sum[SPEED_W-1:0];
    assign timer_inc = (timer_q == TIMER_LAST) ? 6'd0 : timer_q + 6'd1;

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) so no path through the case
        // below can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        pause_last_d = sample ? bus.pause : pause_last_q;
        update_d     = frame_edge && (state_q != ST_PAUSED);
        timer_d      = update_q ? timer_inc : timer_q;
        speed_d      = speed_q;
        start_d      = start_q;
        restart_d    = 1'b0;
        has_obs_d    = has_obs_q;
        high_score_d = high_score_q;
        new_high_d   = 1'b0;
        clear_cnt_d  = clear_cnt_q;
        crash_cnt_d  = crash_cnt_q;

        case (state_q)
            ST_WAITING: begin
                if (update_q && bus.jumping) begin
                    state_d     = ST_RUNNING;
                    speed_d     = SPEED_START;
                    start_d     = 1'b1;
                    clear_cnt_d = '0;
                end
            end

            ST_RUNNING: begin
                // A collision wins over everything, even when it lands between frames.
                if (bus.crashed) begin
                    state_d     = ST_CRASHED;
                    crash_cnt_d = '0;
                    if (bus.score > high_score_q) begin
                        high_score_d = bus.score;
                        new_high_d   = 1'b1;
                    end
                end else if (update_q && pause_press) begin
                    state_d = ST_PAUSED;
                end else if (update_q) begin
                    speed_d = speed_inc;
                    if (clear_cnt_q == CLEAR_MAX) begin
                        has_obs_d = 1'b1;
                    end else begin
                        clear_cnt_d = clear_cnt_q + CLEAR_W'(1);
                    end
                end
            end

            ST_PAUSED: begin
                if (frame_edge && pause_press) begin
                    state_d = ST_RUNNING;
                end
            end

            default: begin
                if (update_q) begin
                    if (bus.jumping && (crash_cnt_q == CRASH_MAX)) begin
                        state_d     = ST_RUNNING;
                        restart_d   = 1'b1;
                        speed_d     = SPEED_START;
                        clear_cnt_d = '0;
                        has_obs_d   = 1'b0;
                    end else if (crash_cnt_q != CRASH_MAX) begin
                        crash_cnt_d = crash_cnt_q + CRASH_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WAITING;
            pf_last_q    <= 1'b0;
            pause_last_q <= 1'b0;
            update_q     <= 1'b0;
            timer_q      <= '0;
            speed_q      <= '0;
            start_q      <= 1'b0;
            restart_q    <= 1'b0;
            has_obs_q    <= 1'b0;
            high_score_q <= '0;
            new_high_q   <= 1'b0;
            clear_cnt_q  <= '0;
            crash_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pf_last_q    <= bus.painter_finished;
            pause_last_q <= pause_last_d;
            update_q     <= update_d;
            timer_q      <= timer_d;
            speed_q      <= speed_d;
            start_q      <= start_d;
            restart_q    <= restart_d;
            has_obs_q    <= has_obs_d;
            high_score_q <= high_score_d;
            new_high_q   <= new_high_d;
            clear_cnt_q  <= clear_cnt_d;
            crash_cnt_q  <= crash_cnt_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.update        = update_q;
    assign bus.timer         = timer_q;
    assign bus.speed         = speed_q;
    assign bus.start         = start_q;
    assign bus.restart       = restart_q;
    assign bus.has_obstacles = has_obs_q;
    assign bus.rng_load      = (state_q == ST_WAITING);
    assign bus.high_score    = high_score_q;
    assign bus.new_high      = new_high_q;

endmodule
